// File: rtl/pooling_controller_if.sv
// Handshake and memory-bus bundle for the 2x2 average-pooling controller.
// The master side is the controller; the slave side is the memory/host environment.
interface pooling_controller_if #(
    parameter int ADDR_W = 10
);
    logic                     start;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [15:0]       rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [13:0]              wr_data;
    logic                     busy;
    logic                     finish;

    modport master (
        input  start, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, finish
    );

    modport slave (
        output start, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, finish
    );
endinterface

// File: rtl/pooling_controller.sv
// 2x2 average pooling over an N x N signed feature map: four reads per window,
// one capture cycle for the late read data, then one write of the averaged pixel.
module pooling_controller #(
    parameter int N      = 28,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    pooling_controller_if.master bus
);
    localparam int                HALF = N / 2;
    localparam logic [ADDR_W-1:0] NW   = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] HW   = ADDR_W'(HALF);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(HALF - 1);

    typedef enum logic [2:0] {IDLE, RD, TAIL, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  r_q, r_d, c_q, c_d;
    logic [1:0]         k_q, k_d;
    logic signed [17:0] acc_q, acc_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [13:0]        wr_data_q, wr_data_d;

    logic [ADDR_W-1:0]  row, col, rd_addr_now, wr_addr_now;
    logic signed [17:0] avg;
    logic signed [17:0] pix;

    always_comb begin
        row         = (r_q << 1) + ADDR_W'(k_q[1]);
        col         = (c_q << 1) + ADDR_W'(k_q[0]);
        rd_addr_now = row * NW + col;
        wr_addr_now = r_q * HW + c_q;
        avg         = acc_q >>> 2;
        pix         = {{2{bus.rd_data[15]}}, bus.rd_data};
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        acc_d     = acc_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RD;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            RD: begin
                rd_addr_d = rd_addr_now;
                // data for the previous read lands now; k=0 has nothing pending
                if (k_q != 2'd0) acc_d = acc_q + pix;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = TAIL;
            end
            TAIL: begin
                acc_d   = acc_q + pix;
                state_d = WR;
            end
            WR: begin
                wr_addr_d = wr_addr_now;
                wr_data_d = avg[13:0];
                acc_d     = '0;
                k_d       = '0;
                if (c_q < LAST) begin
                    c_d     = c_q + 1'b1;
                    state_d = RD;
                end else if (r_q < LAST) begin
                    c_d     = '0;
                    r_d     = r_q + 1'b1;
                    state_d = RD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Strobed outputs are live in their state and hold the last issued value otherwise.
    assign bus.rd_en   = (state_q == RD);
    assign bus.rd_addr = bus.rd_en ? rd_addr_now : rd_addr_q;
    assign bus.wr_en   = (state_q == WR);
    assign bus.wr_addr = bus.wr_en ? wr_addr_now : wr_addr_q;
    assign bus.wr_data = bus.wr_en ? avg[13:0] : wr_data_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.finish  = (state_q == DONE);
endmodule

// File: tb/tb_pooling_controller.sv
// Directed bench for pooling_controller: one N=4 and one N=2 instance, each with a
// behavioural one-cycle-latency input memory and a write/read/finish monitor.
module tb_pooling_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pooling_controller_if #(.ADDR_W(5)) b4 ();
    pooling_controller_if #(.ADDR_W(4)) b2 ();

    pooling_controller #(.N(4), .ADDR_W(5)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    pooling_controller #(.N(2), .ADDR_W(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    logic signed [15:0] mem4 [16];
    logic signed [15:0] mem2 [4];

    always @(posedge clk) begin
        if (b4.rd_en) b4.rd_data <= mem4[b4.rd_addr[3:0]];
        if (b2.rd_en) b2.rd_data <= mem2[b2.rd_addr[1:0]];
    end

    int wa[$];
    int wd[$];
    int ra[$];
    int fin_cnt;
    int overlap;
    int cur;
    int n_checks;
    int n_fail;

    always @(negedge clk) begin
        if (cur == 4) begin
            if (b4.wr_en) begin
                wa.push_back(int'(b4.wr_addr));
                wd.push_back(int'(b4.wr_data));
            end
            if (b4.rd_en) ra.push_back(int'(b4.rd_addr));
            if (b4.finish) fin_cnt++;
            if (b4.rd_en && b4.wr_en) overlap++;
        end else begin
            if (b2.wr_en) begin
                wa.push_back(int'(b2.wr_addr));
                wd.push_back(int'(b2.wr_data));
            end
            if (b2.rd_en) ra.push_back(int'(b2.rd_addr));
            if (b2.finish) fin_cnt++;
            if (b2.rd_en && b2.wr_en) overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 4) ? b4.busy : b2.busy;
    endfunction

    function automatic logic fin_of(input int sel);
        return (sel == 4) ? b4.finish : b2.finish;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 4) b4.start = v;
        else          b2.start = v;
    endtask

    // Cycle 0 is the cycle start is high; extra start pulses and rst land in the given cycles.
    task automatic run(input int sel, input int ign_a, input int ign_b, input int rst_at,
                       output int fin_at);
        fin_at = -1;
        wa.delete(); wd.delete(); ra.delete();
        fin_cnt = 0;
        overlap = 0;
        cur     = sel;
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) check("busy_after_start", 32'(busy_of(sel)), 32'd1);
            if (rst_at >= 0 && i == rst_at + 1)
                check("busy_after_rst", 32'(busy_of(sel)), 32'd0);
            if (fin_of(sel) && fin_at < 0) fin_at = i;
            set_start(sel, (i == ign_a) || (i == ign_b));
            rst = (i == rst_at);
            if (fin_at >= 0) break;
        end
        @(negedge clk);
        set_start(sel, 1'b0);
        rst = 1'b0;
        if (fin_at >= 0) check("busy_after_finish", 32'(busy_of(sel)), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_writes4(input string tag, input int e0, input int e1, input int e2,
                               input int e3);
        int exp_d [4];
        exp_d = '{e0, e1, e2, e3};
        check({tag, "_nwr"}, 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_waddr"}, (i < wa.size()) ? 32'(wa[i]) : 32'hFFFF_FFFF, 32'(i));
            check({tag, "_wdata"}, (i < wd.size()) ? 32'(wd[i]) : 32'hFFFF_FFFF, 32'(exp_d[i]));
        end
        check({tag, "_nfinish"}, 32'(fin_cnt), 32'd1);
        check({tag, "_rdwr_overlap"}, 32'(overlap), 32'd0);
    endtask

    initial begin
        int f;
        n_checks = 0;
        n_fail   = 0;
        cur      = 4;
        rst      = 1'b1;
        b4.start = 1'b0;
        b2.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(b4.busy),    32'd0);
        check("rst_rd_en",   32'(b4.rd_en),   32'd0);
        check("rst_wr_en",   32'(b4.wr_en),   32'd0);
        check("rst_finish",  32'(b4.finish),  32'd0);
        check("rst_rd_addr", 32'(b4.rd_addr), 32'd0);
        check("rst_wr_addr", 32'(b4.wr_addr), 32'd0);
        check("rst_wr_data", 32'(b4.wr_data), 32'd0);
        check("rst_busy2",   32'(b2.busy),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Flat map of 4s: every window averages to 4.
        for (int i = 0; i < 16; i++) mem4[i] = 16'sd4;
        run(4, -1, -1, -1, f);
        check("flat_finish_cycle", 32'(f), 32'd25);
        chk_writes4("flat", 4, 4, 4, 4);
        check("hold_wr_addr", 32'(b4.wr_addr), 32'd3);
        check("hold_wr_data", 32'(b4.wr_data), 32'd4);
        check("hold_rd_addr", 32'(b4.rd_addr), 32'd15);

        // Ramp map: sums 10,18,42,50.
        for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
        run(4, -1, -1, -1, f);
        check("ramp_finish_cycle", 32'(f), 32'd25);
        chk_writes4("ramp", 2, 4, 10, 12);
        check("ramp_nreads", 32'(ra.size()), 32'd16);
        check("ramp_read1", (ra.size() > 1) ? 32'(ra[1]) : 32'hFFFF_FFFF, 32'd1);
        check("ramp_read2", (ra.size() > 2) ? 32'(ra[2]) : 32'hFFFF_FFFF, 32'd4);
        check("ramp_read7", (ra.size() > 7) ? 32'(ra[7]) : 32'hFFFF_FFFF, 32'd7);

        // Start re-pulsed mid-run must be ignored.
        run(4, 3, 10, -1, f);
        check("ign_finish_cycle", 32'(f), 32'd25);
        chk_writes4("ign", 2, 4, 10, 12);

        // Reset in the second window's read phase aborts with no further write.
        run(4, -1, -1, 8, f);
        check("abort_no_finish", 32'(f), 32'hFFFF_FFFF);
        check("abort_nwr", 32'(wa.size()), 32'd1);
        check("abort_wr_data", 32'(b4.wr_data), 32'd0);
        run(4, -1, -1, -1, f);
        check("post_abort_finish_cycle", 32'(f), 32'd25);
        chk_writes4("post_abort", 2, 4, 10, 12);

        // Reset wins over a simultaneous start.
        rst      = 1'b1;
        b4.start = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        b4.start = 1'b0;
        check("rst_over_start", 32'(b4.busy), 32'd0);
        @(negedge clk);
        check("rst_over_start_idle", 32'(b4.busy), 32'd0);

        // N=2: single window; start during the finish cycle must be ignored.
        mem2[0] = 16'sd1; mem2[1] = 16'sd2; mem2[2] = 16'sd3; mem2[3] = 16'sd5;
        run(2, 7, -1, -1, f);
        check("n2_finish_cycle", 32'(f), 32'd7);
        check("n2_nwr", 32'(wa.size()), 32'd1);
        check("n2_waddr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 32'd0);
        check("n2_wdata", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFF_FFFF, 32'd2);
        check("n2_nreads", 32'(ra.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("n2_raddr", (i < ra.size()) ? 32'(ra[i]) : 32'hFFFF_FFFF, 32'(i));
        check("n2_nfinish", 32'(fin_cnt), 32'd1);

        // Negative sum -5 floors to -2.
        mem2[0] = -16'sd1; mem2[1] = -16'sd1; mem2[2] = -16'sd1; mem2[3] = -16'sd2;
        run(2, -1, -1, -1, f);
        check("neg_finish_cycle", 32'(f), 32'd7);
        check("neg_wdata", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFF_FFFF, 32'h3FFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pooling_controller.md
POOLING_CONTROLLER -- requirements
Module: pooling_controller

Interface
REQ-001 Parameter N, default 28: input feature-map side length in pixels; SHALL be even and >= 2.
REQ-002 Parameter ADDR_W, default 10: memory address width; SHALL satisfy 2^ADDR_W >= N*N.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins pooling of one full feature map.
REQ-006 rd_en  output  1  input-memory read strobe.
REQ-007 rd_addr  output  ADDR_W  input-memory address, row-major (row*N + col).
REQ-008 rd_data  input  16  signed pixel, valid exactly 1 cycle after the rd_en cycle.
REQ-009 wr_en  output  1  output-memory write strobe.
REQ-010 wr_addr  output  ADDR_W  output-memory address, row-major (r*(N/2) + c).
REQ-011 wr_data  output  14  pooled pixel.
REQ-012 busy  output  1  high from the cycle after an accepted start until finish.
REQ-013 finish  output  1  one-cycle pulse when the whole map is written.

Function
REQ-014 The FSM SHALL have states IDLE, RD, TAIL, WR, DONE.
REQ-015 IDLE: start=1 -> RD with window r=0, c=0, sub-index k=0, accumulator cleared; start=0 -> stay.
REQ-016 RD: each cycle assert rd_en with rd_addr = (2r+dy)*N + (2c+dx), k=0..3 mapping to (dy,dx) = (0,0),(0,1),(1,0),(1,1); after k=3 -> TAIL.
REQ-017 Accumulator SHALL add sign-extended rd_data in each cycle following an rd_en cycle (RD k=1..3 and TAIL), 18-bit signed, no overflow possible.
REQ-018 TAIL: rd_en=0; captures the 4th pixel -> WR.
REQ-019 WR: wr_en=1 for one cycle; wr_addr = r*(N/2)+c; wr_data = bits [13:0] of (sum arithmetically shifted right by 2).
REQ-020 After WR: if c < N/2-1 -> c+1, RD; else if r < N/2-1 -> c=0, r+1, RD; else -> DONE; accumulator SHALL clear on each new window.
REQ-021 DONE: finish=1 for one cycle -> IDLE.
REQ-022 Each window SHALL take exactly 6 cycles (4 RD, 1 TAIL, 1 WR); finish SHALL occur 6*(N/2)^2 + 1 cycles after the start cycle.
REQ-023 start while not in IDLE SHALL be ignored, with no effect on counters or outputs.
REQ-024 start in the same cycle as the DONE finish pulse SHALL be ignored; a new run is accepted only from IDLE.
REQ-025 rd_en and wr_en SHALL never be high in the same cycle.
REQ-026 busy SHALL be 1 in RD, TAIL, WR, DONE and 0 in IDLE.
REQ-027 When rd_en=0, rd_addr SHALL hold its last value; when wr_en=0, wr_addr and wr_data SHALL hold their last values.

Reset
REQ-028 rst=1 SHALL force IDLE, r=c=k=0, accumulator=0, and rd_en=wr_en=busy=finish=0, rd_addr=wr_addr=0, wr_data=0 at the next edge.
REQ-029 rst asserted mid-run SHALL abort without a further write; any in-flight read data SHALL be discarded.
REQ-030 rst has priority over start in the same cycle.

Verification
REQ-031 N=4, all pixels 4, start pulse -> 4 writes, addrs 0,1,2,3, wr_data=4 each; finish at cycle 25 after start.
REQ-032 N=2, pixels 1,2,3,5 -> single write at addr 0, wr_data=2 (11>>2); reads at addrs 0,1,2,3 in order.
REQ-033 N=2, pixels -1,-1,-1,-2 -> wr_data=14'h3FFE (-5>>>2 = -2).
REQ-034 N=4: start re-pulsed at cycles 3 and 10 of a run -> ignored; exactly 4 writes and one finish.
REQ-035 N=4: rst at cycle 8 (second window RD) -> busy=0 next cycle, no further wr_en; subsequent start -> full correct run.
REQ-036 N=4, pixel(row,col) = row*4+col -> wr_data 2,4,10,12 at addrs 0..3 (sums 10,18,42,50).
